// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle control FSM for the 16-bit CPU.
// Sequences FETCH -> DECODE -> EXEC -> MEM -> WB for one instruction at a time and drives the
// PC, IR, register-file, ALU and memory enables. Outputs are Moore from state + latched op,
// except for the live opcode in DECODE, zero in EXEC and mem_ready in FETCH/MEM.
// A watchdog halts the FSM with a sticky mem_err when memory never answers.
//
// Optional feature: define CTRL_PERF_CNT_EN to build the retired-instruction counter.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   opcode, func          instruction fields from instruction_decode, valid in DECODE
//   zero                  ALU zero flag, sampled in EXEC
//   mem_ready             memory completes the current access this cycle
//   pc_write, pc_src      PC load strobe and source (0 PC+2, 1 branch, 2 jump)
//   ir_write              IR load strobe
//   mem_read, mem_write   memory requests; iord selects address (0 PC, 1 ALU)
//   alu_op, alu_src_imm   ALU operation, B operand from sign-extended imm6
//   reg_write, reg_dst_rd, mem_to_reg   register-file write controls
//   illegal_op            one-cycle pulse on an undefined opcode
//   mem_err, halted       sticky memory timeout flag, FSM in HALT
//   instr_count           retired instructions (tied to 0 without CTRL_PERF_CNT_EN)
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic [2:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic [2:0]       alu_op,
  output logic             alu_src_imm,
  output logic             reg_write,
  output logic             reg_dst_rd,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic             mem_err,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [3:0] OpR    = 4'h0;
  localparam logic [3:0] OpAddi = 4'h1;
  localparam logic [3:0] OpAndi = 4'h2;
  localparam logic [3:0] OpOri  = 4'h3;
  localparam logic [3:0] OpSlti = 4'h4;
  localparam logic [3:0] OpLw   = 4'h5;
  localparam logic [3:0] OpSw   = 4'h6;
  localparam logic [3:0] OpBeq  = 4'h7;
  localparam logic [3:0] OpBne  = 4'h8;
  localparam logic [3:0] OpJ    = 4'h9;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q;
  logic [2:0]       func_q;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             mem_err_q, mem_err_d;
  logic             timeout;
  logic             dec_illegal;
  logic             is_branch;

  assign dec_illegal = (opcode >= 4'hA) && (opcode <= 4'hE);
  assign is_branch   = (op_q == OpBeq) || (op_q == OpBne);

  // A ready arriving on the timeout cycle still completes the access.
  assign timeout = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready &&
                   (wait_q == WaitW'(MEM_TIMEOUT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      op_q      <= 4'h0;
      func_q    <= 3'h0;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
      if (state_q == StDecode) begin
        op_q   <= opcode;
        func_q <= func;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (mem_ready)    state_d = StDecode;
        else if (timeout) state_d = StHalt;
      end
      StDecode: begin
        if (opcode == OpJ || dec_illegal) state_d = StFetch;
        else if (opcode == OpHalt)        state_d = StHalt;
        else                              state_d = StExec;
      end
      StExec: begin
        if (is_branch)                         state_d = StFetch;
        else if (op_q == OpLw || op_q == OpSw) state_d = StMem;
        else                                   state_d = StWb;
      end
      StMem: begin
        if (mem_ready)    state_d = (op_q == OpLw) ? StWb : StFetch;
        else if (timeout) state_d = StHalt;
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase

    // Wait counter only advances while stalled; any state change restarts it.
    if (state_d != state_q) wait_d = '0;
    else if (((state_q == StFetch) || (state_q == StMem)) && !mem_ready)
      wait_d = wait_q + WaitW'(1);
    else wait_d = wait_q;

    mem_err_d = mem_err_q | timeout;
  end

  // Output logic
  always_comb begin
    pc_write    = 1'b0;
    pc_src      = 2'd0;
    ir_write    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    alu_op      = 3'b000;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    reg_dst_rd  = 1'b0;
    mem_to_reg  = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      StDecode: begin
        if (opcode == OpJ) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
        end
        illegal_op = dec_illegal;
      end
      StExec: begin
        case (op_q)
          OpR: alu_op = func_q;
          OpAddi, OpLw, OpSw: begin
            alu_op      = 3'b000;
            alu_src_imm = 1'b1;
          end
          OpAndi: begin
            alu_op      = 3'b010;
            alu_src_imm = 1'b1;
          end
          OpOri: begin
            alu_op      = 3'b011;
            alu_src_imm = 1'b1;
          end
          OpSlti: begin
            alu_op      = 3'b100;
            alu_src_imm = 1'b1;
          end
          OpBeq, OpBne: begin
            alu_op   = 3'b001;
            pc_write = (op_q == OpBeq) ? zero : !zero;
            pc_src   = pc_write ? 2'd1 : 2'd0;
          end
          default: ;
        endcase
      end
      StMem: begin
        iord      = 1'b1;
        mem_read  = (op_q == OpLw);
        mem_write = (op_q == OpSw);
      end
      StWb: begin
        reg_write  = 1'b1;
        reg_dst_rd = (op_q == OpR);
        mem_to_reg = (op_q == OpLw);
      end
      default: ;
    endcase
  end

  assign mem_err = mem_err_q;
  assign halted  = (state_q == StHalt);

`ifdef CTRL_PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  // High on the final cycle of every instruction except halt.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      StDecode: retire = (opcode == OpJ) || dec_illegal;
      StExec:   retire = is_branch;
      StMem:    retire = mem_ready && (op_q == OpSw);
      StWb:     retire = 1'b1;
      default:  retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = '0;
`endif

endmodule
